// File: rtl/alu_pkg.sv
// alu_pkg: op-code constants, arbiter FSM encoding and counter limit shared by alu and alu_arbiter
package alu_pkg;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;
   localparam logic [7:0] OP_COUNT_MAX = 8'd255;
   typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/alu.sv
// alu: 2-bit operand combinational ALU producing a 4-bit result
module alu
   import alu_pkg::*;
(
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic [1:0] sel,
   output logic [3:0] y
);
   logic [3:0] ax, bx;
   always_comb begin
      ax = {2'b00, a};
      bx = {2'b00, b};
      y  = (sel == ALU_ADD) ? ax + bx :
           (sel == ALU_SUB) ? ax - bx :
           (sel == ALU_MUL) ? ax * bx : ax & bx;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu between two requesters,
// one operation in flight, result held until the consumer accepts it
module alu_arbiter
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic       req1_valid,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic [1:0] req0_a,
   input  logic [1:0] req0_b,
   input  logic [1:0] req0_sel,
   input  logic [1:0] req1_a,
   input  logic [1:0] req1_b,
   input  logic [1:0] req1_sel,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_y,
   output logic       res_id,
   output logic [7:0] op_count
);
   state_t     state, state_nx;
   logic       ptr, id_q, grant0, grant1, issue;
   logic [1:0] a_q, b_q, sel_q;
   logic [3:0] y;

   alu u_alu (.a(a_q), .b(b_q), .sel(sel_q), .y(y));

   // a lone valid requester wins; on contention the pointer decides
   always_comb begin
      grant0     = req0_valid & (~req1_valid | ~ptr);
      grant1     = req1_valid & (~req0_valid | ptr);
      req0_ready = (state == IDLE) & ~reset & grant0;
      req1_ready = (state == IDLE) & ~reset & grant1;
      issue      = req0_ready | req1_ready;
      state_nx   = (state == IDLE) ? (issue ? EXEC : IDLE) :
                   (state == EXEC) ? DONE :
                   (res_valid & res_ready) ? IDLE : DONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sel_q     <= '0;
         id_q      <= 1'b0;
         res_valid <= 1'b0;
         res_y     <= '0;
         res_id    <= 1'b0;
         op_count  <= '0;
      end else begin
         state <= state_nx;
         if (issue) begin
            a_q   <= req1_ready ? req1_a : req0_a;
            b_q   <= req1_ready ? req1_b : req0_b;
            sel_q <= req1_ready ? req1_sel : req0_sel;
            id_q  <= req1_ready;
         end
         if (state == EXEC) begin
            res_y     <= y;
            res_id    <= id_q;
            res_valid <= 1'b1;
         end
         if (state == DONE && res_valid && res_ready) begin
            res_valid <= 1'b0;
            ptr       <= ~res_id;
            op_count  <= (op_count == OP_COUNT_MAX) ? op_count : op_count + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure, reset abort and saturation
module tb_alu_arbiter;
   logic       clk = 0, reset = 1;
   logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [1:0] req0_a = 0, req0_b = 0, req0_sel = 0, req1_a = 0, req1_b = 0, req1_sel = 0;
   logic       res_valid, res_ready = 0, res_id;
   logic [3:0] res_y;
   logic [7:0] op_count;
   int         n_cmp = 0, n_err = 0;

   alu_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_y(res_y), .res_id(res_id), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1;
      tick();
      tick();
      reset = 0;
      #1;
   endtask

   task automatic wait_res();
      int n = 0;
      while (!res_valid && n < 20) begin
         tick();
         n++;
      end
      chk("res_valid_timeout", res_valid, 1);
   endtask

   logic [0:0] ids [4];

   initial begin
      // reset values, readies masked during reset
      req0_valid = 1;
      req1_valid = 1;
      tick();
      tick();
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_y", res_y, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_op_count", op_count, 0);

      // single request: 2+3
      req1_valid = 0;
      req0_a = 2; req0_b = 3; req0_sel = 2'b00; res_ready = 1;
      reset = 0;
      #1;
      chk("single_req0_ready_c0", req0_ready, 1);
      chk("single_req1_ready_c0", req1_ready, 0);
      tick();
      req0_valid = 0;
      chk("single_res_valid_c1", res_valid, 0);
      chk("single_ready_c1", req0_ready, 0);
      tick();
      chk("single_res_valid_c2", res_valid, 1);
      chk("single_res_y", res_y, 5);
      chk("single_res_id", res_id, 0);
      tick();
      chk("single_res_valid_c3", res_valid, 0);
      chk("single_op_count", op_count, 1);

      // contention after reset: req0 3*3 first, then req1 1-2
      do_reset();
      req0_valid = 1; req0_a = 3; req0_b = 3; req0_sel = 2'b10;
      req1_valid = 1; req1_a = 1; req1_b = 2; req1_sel = 2'b01;
      #1;
      chk("cont_req0_ready", req0_ready, 1);
      chk("cont_req1_ready", req1_ready, 0);
      tick();
      req0_valid = 0;
      chk("cont_req1_ready_exec", req1_ready, 0);
      tick();
      chk("cont_req1_ready_done", req1_ready, 0);
      chk("cont_first_y", res_y, 9);
      chk("cont_first_id", res_id, 0);
      tick();
      chk("cont_req1_ready_idle", req1_ready, 1);
      tick();
      req1_valid = 0;
      tick();
      chk("cont_second_valid", res_valid, 1);
      chk("cont_second_y", res_y, 4'hf);
      chk("cont_second_id", res_id, 1);
      tick();
      chk("cont_op_count", op_count, 2);

      // round robin: both continuously valid, req0 1+2=3, req1 3&1=1
      do_reset();
      req0_valid = 1; req0_a = 1; req0_b = 2; req0_sel = 2'b00;
      req1_valid = 1; req1_a = 3; req1_b = 1; req1_sel = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_res();
         ids[i] = res_id;
         chk($sformatf("rr_y_%0d", i), res_y, (i % 2) ? 8'd1 : 8'd3);
         tick();
      end
      for (int i = 0; i < 4; i++) chk($sformatf("rr_id_%0d", i), ids[i], i[0]);
      chk("rr_op_count", op_count, 4);

      // backpressure: req0 3-2=1 held for 5 cycles, res_ready high during EXEC is harmless
      do_reset();
      res_ready = 0;
      req0_valid = 1; req0_a = 3; req0_b = 2; req0_sel = 2'b01;
      req1_valid = 1;
      tick();
      req0_valid = 0;
      res_ready = 1;
      chk("bp_exec_valid", res_valid, 0);
      tick();
      res_ready = 0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_valid_%0d", i), res_valid, 1);
         chk($sformatf("bp_y_%0d", i), res_y, 1);
         chk($sformatf("bp_id_%0d", i), res_id, 0);
         chk($sformatf("bp_rdy_%0d", i), {req0_ready, req1_ready}, 0);
         chk($sformatf("bp_cnt_%0d", i), op_count, 0);
         tick();
      end
      res_ready = 1;
      tick();
      chk("bp_accept_valid", res_valid, 0);
      chk("bp_accept_cnt", op_count, 1);
      chk("bp_req1_next", req1_ready, 1);
      req1_valid = 0;

      // reset in EXEC aborts the operation
      do_reset();
      req0_valid = 1; req0_a = 2; req0_b = 2; req0_sel = 2'b10;
      req1_valid = 1;
      tick();
      reset = 1;
      #1;
      chk("abort_rdy_in_reset", {req0_ready, req1_ready}, 0);
      tick();
      reset = 0;
      #1;
      chk("abort_res_valid", res_valid, 0);
      chk("abort_op_count", op_count, 0);
      chk("abort_idle_ptr0_req0", req0_ready, 1);
      chk("abort_idle_ptr0_req1", req1_ready, 0);
      req0_a = 1; req0_b = 3; req0_sel = 2'b00;
      tick();
      req0_valid = 0;
      req1_valid = 0;
      tick();
      chk("abort_next_y", res_y, 4);
      tick();
      chk("abort_next_cnt", op_count, 1);

      // saturation at 255
      do_reset();
      req0_valid = 1; req0_a = 1; req0_b = 1; req0_sel = 2'b00;
      for (int i = 0; i < 260; i++) begin
         wait_res();
         tick();
         if (i == 254) chk("sat_255", op_count, 255);
      end
      chk("sat_260", op_count, 255);
      req0_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL use clock and reset as decided: one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-004 SHALL have ports: req0_valid / req1_valid  in  1 each  requester n has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  out  1 each  requester n's operation accepted this cycle (handshake = valid & ready).
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  in  2 each  operands; req0_sel, req1_sel  in  2 each  ALU op select.
REQ-007 SHALL have ports: res_valid  out  1  result available; res_ready  in  1  consumer accepts result.
REQ-008 SHALL have ports: res_y  out  4  ALU result; res_id  out  1  requester that issued it (0/1).
REQ-009 SHALL have ports: op_count  out  8  completed operations, saturating.

Function
REQ-010 SHALL share one alu instance (A, B 2-bit, sel 2-bit, Y 4-bit) between two requesters.
REQ-011 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-012 IDLE: SHALL assert at most one reqN_ready, combinationally, only for a valid requester; both ready low in EXEC and DONE.
REQ-013 IDLE: only one valid -> that requester granted regardless of priority pointer.
REQ-014 IDLE: both valid -> requester indicated by priority pointer granted; other waits.
REQ-015 On handshake SHALL latch a, b, sel, id into operand registers and go IDLE->EXEC.
REQ-016 EXEC: SHALL drive alu from operand registers, register Y into res_y, id into res_id, set res_valid, go EXEC->DONE (one cycle).
REQ-017 DONE: SHALL hold res_valid, res_y, res_id stable until res_ready high; on res_valid & res_ready, clear res_valid, go DONE->IDLE.
REQ-018 On result handshake SHALL set priority pointer to the requester NOT just served and increment op_count, saturating at 255.
REQ-019 Latency: handshake in cycle t -> res_valid high in cycle t+2; minimum issue interval 3 cycles (res_ready held high).
REQ-020 res_ready high while res_valid low SHALL have no effect.
REQ-021 reqN_valid dropping while not granted SHALL be legal and SHALL have no effect.
REQ-022 ALU op encoding: 00 ADD (A+B), 01 SUB (A-B, 4-bit two's complement), 10 MUL (A*B), 11 AND (zero-extended A&B).

Reset
REQ-023 Reset SHALL force state IDLE, res_valid 0, res_y 0, res_id 0, op_count 0, priority pointer 0, operand registers 0.
REQ-024 Reset in EXEC or DONE SHALL abort the operation; the result SHALL NOT be presented and op_count SHALL NOT increment.
REQ-025 reqN_ready SHALL be 0 during any cycle reset is high.

Structure
REQ-026 Shared package alu_pkg SHALL hold op-code constants (ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND), FSM state encoding, and OP_COUNT_MAX=255.
REQ-027 SHALL instantiate the existing alu module as its single sub-module; no arithmetic SHALL be duplicated in alu_arbiter.

Verification
REQ-028 Single request: req0 a=2, b=3, sel=00, res_ready=1 -> req0_ready in cycle 0, res_valid cycle 2, res_y=5, res_id=0, op_count=1.
REQ-029 Contention: both valid after reset, req0 a=3,b=3,sel=10; req1 a=1,b=2,sel=01 -> req0 served first (res_y=9,id=0), then req1 (res_y=4'b1111,id=1).
REQ-030 Round-robin: both continuously valid for 4 ops -> res_id sequence 0,1,0,1; op_count=4.
REQ-031 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_y/res_id stable, both readies low, op_count unchanged; accepted on res_ready=1.
REQ-032 Reset mid-op: assert reset in EXEC -> next cycle res_valid=0, op_count=0, pointer=0, state IDLE.
REQ-033 Saturation: 260 completed ops -> op_count=255.
